// File: rtl/cfg_uart.sv
// cfg_uart: configuration-port UART endpoint. Receives 24-bit commands as three 8N1
// bytes on RX_C and returns 16-bit responses as two 8N1 bytes on TX_C, independently.
module cfg_uart #(
  parameter int BAUD_DIV = 4340,
  parameter int TO_BITS  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX_C,
  output logic        TX_C,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [15:0] rsp,
  input  logic        send_rsp,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam int CW     = $clog2(BAUD_DIV);
  localparam int TO_LIM = TO_BITS * BAUD_DIV;
  localparam int TW     = $clog2(TO_LIM + 1);

  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_END   = TW'(TO_LIM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_e;

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  logic          rx_meta;
  logic          rx_s;
  logic          rx_prev;
  logic          rx_fall;
  uart_state_e   rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic [7:0]    byte0;
  logic [7:0]    byte1;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] to_cnt;

  // NOTE: non-blocking assignments make these three flops a real shift chain;
  // blocking ones would collapse the synchronizer into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX_C;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign rx_fall = rx_prev & ~rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      byte0    <= '0;
      byte1    <= '0;
      byte_cnt <= '0;
      to_cnt   <= '0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
    end else begin
      // A set of cmd_rdy later in this block overrides this clear.
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;

      case (rx_state)
        S_IDLE: begin
          if (rx_fall) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
            to_cnt   <= '0;
            if (byte_cnt == 2'd0) cmd_rdy <= 1'b0;
          end else if (byte_cnt != 2'd0) begin
            // Abandon a partial command if the master goes quiet too long.
            if (to_cnt == TO_END) begin
              byte_cnt <= '0;
              to_cnt   <= '0;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
        end

        S_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
            if (rx_s) begin
              case (byte_cnt)
                2'd0: begin
                  byte0    <= rx_shift;
                  byte_cnt <= 2'd1;
                end
                2'd1: begin
                  byte1    <= rx_shift;
                  byte_cnt <= 2'd2;
                end
                default: begin
                  cmd      <= {byte0, byte1, rx_shift};
                  cmd_rdy  <= 1'b1;
                  byte_cnt <= 2'd0;
                end
              endcase
            end else begin
              byte_cnt <= 2'd0;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end

        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------------
  uart_state_e   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic          tx_sel;
  logic [15:0]   tx_word;
  logic [7:0]    tx_byte;

  assign tx_byte = tx_sel ? tx_word[7:0] : tx_word[15:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sel   <= 1'b0;
      tx_word  <= '0;
      TX_C     <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      case (tx_state)
        S_IDLE: begin
          if (send_rsp) begin
            tx_word  <= rsp;
            tx_busy  <= 1'b1;
            tx_sel   <= 1'b0;
            tx_cnt   <= '0;
            TX_C     <= 1'b0;
            tx_state <= S_START;
          end
        end

        S_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            TX_C     <= tx_byte[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              TX_C     <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              TX_C   <= tx_byte[tx_bit + 3'd1];
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (!tx_sel) begin
              // Second byte's start bit follows the first stop bit with no gap.
              tx_sel   <= 1'b1;
              TX_C     <= 1'b0;
              tx_state <= S_START;
            end else begin
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end

        default: tx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_uart.sv
// tb_cfg_uart: randomized self-checking bench for cfg_uart, comparing the DUT against a
// byte-level model of the command receiver and a bit-level model of the response frame.
module tb_cfg_uart;

  localparam int BD = 16;
  localparam int TO = 32;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic        rx_line     = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_rsp    = 1'b0;
  logic [15:0] rsp         = '0;
  logic        tx_line;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        tx_busy;
  logic        tx_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes of the command being assembled and the expected outputs.
  logic [7:0]  pend[$];
  logic [23:0] exp_cmd  = '0;
  logic        exp_rdy  = 1'b0;
  int          gap_bits = 0;

  cfg_uart #(.BAUD_DIV(BD), .TO_BITS(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .RX_C(rx_line),
    .TX_C(tx_line),
    .cmd(cmd),
    .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .rsp(rsp),
    .send_rsp(send_rsp),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Line level of each of the 20 bit slots of a response frame, in send order.
  function automatic logic [19:0] frame_bits(input logic [15:0] w);
    logic [7:0] b;
    for (int i = 0; i < 20; i++) begin
      b = (i < 10) ? w[15:8] : w[7:0];
      case (i % 10)
        0:       frame_bits[i] = 1'b0;
        9:       frame_bits[i] = 1'b1;
        default: frame_bits[i] = b[(i % 10) - 1];
      endcase
    end
  endfunction

  task automatic model_start();
    if (pend.size() != 0 && gap_bits > TO) pend.delete();
    if (pend.size() == 0) exp_rdy = 1'b0;
    gap_bits = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    model_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_line = f[i];
      repeat (BD - 1) @(negedge clk);
    end
    @(negedge clk);
    rx_line = 1'b1;
    if (stop_ok) begin
      pend.push_back(b);
      if (pend.size() == 3) begin
        exp_cmd = {pend[0], pend[1], pend[2]};
        exp_rdy = 1'b1;
        pend.delete();
      end
    end else begin
      pend.delete();
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BD) @(negedge clk);
    gap_bits += n;
  endtask

  task automatic glitch();
    model_start();
    @(negedge clk);
    rx_line = 1'b0;
    repeat (6) @(negedge clk);
    rx_line = 1'b1;
    repeat (2 * BD) @(negedge clk);
    gap_bits += 2;
  endtask

  task automatic pulse_send(input logic [15:0] w);
    @(negedge clk);
    rsp      = w;
    send_rsp = 1'b1;
    @(negedge clk);
    send_rsp = 1'b0;
  endtask

  task automatic capture_frame(output logic [19:0] bits, output logic found);
    int w;
    w = 0;
    while (tx_line !== 1'b0 && w < 40 * BD) begin
      @(negedge clk);
      w++;
    end
    found = (tx_line === 1'b0);
    bits  = '0;
    if (found) begin
      repeat (BD / 2) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
        bits[i] = tx_line;
        if (i < 19) repeat (BD) @(negedge clk);
      end
    end
  endtask

  task automatic wait_done(output logic seen);
    int w;
    w = 0;
    while (tx_done !== 1'b1 && w < 4 * BD) begin
      @(negedge clk);
      w++;
    end
    seen = (tx_done === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_line !== 1'b1 || cmd !== 24'h0 || cmd_rdy !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: TX_C=%b cmd=%h cmd_rdy=%b tx_busy=%b tx_done=%b, required 1 000000 0 0 0",
               tx_line, cmd, cmd_rdy, tx_busy, tx_done);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (tx_line !== 1'b1 || cmd_rdy !== 1'b0 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: TX_C=%b cmd_rdy=%b tx_busy=%b, required 1 0 0", tx_line, cmd_rdy, tx_busy);
    end
  endtask

  task automatic test_rx_basic();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h0F, 1'b1);
    checks++;
    if (cmd !== 24'hA53C0F || cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL rx_basic: cmd=%h cmd_rdy=%b, required a53c0f 1", cmd, cmd_rdy);
    end
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
    checks++;
    if (cmd !== 24'hA53C0F || cmd_rdy !== 1'b0) begin
      failures++;
      $display("FAIL rx_consume: cmd=%h cmd_rdy=%b, required a53c0f 0", cmd, cmd_rdy);
    end
    idle_bits(2);
  endtask

  task automatic test_tx_basic();
    logic [19:0] fb;
    int          bad[20];
    int          busy_err;
    fb       = frame_bits(16'h12F0);
    busy_err = 0;
    for (int i = 0; i < 20; i++) bad[i] = 0;
    pulse_send(16'h12F0);
    for (int n = 0; n <= 20 * BD; n++) begin
      if (n < 20 * BD) begin
        if (tx_line !== fb[n / BD]) bad[n / BD]++;
        if (tx_busy !== 1'b1 || tx_done !== 1'b0) busy_err++;
      end else begin
        checks++;
        if (tx_done !== 1'b1 || tx_busy !== 1'b0 || tx_line !== 1'b1) begin
          failures++;
          $display("FAIL tx_done_timing: tx_done=%b tx_busy=%b TX_C=%b at clock 320, required 1 0 1",
                   tx_done, tx_busy, tx_line);
        end
      end
      if (n == 99) begin
        rsp      = 16'hFFFF;
        send_rsp = 1'b1;
      end
      if (n == 100) send_rsp = 1'b0;
      if (n < 20 * BD) @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bad[i] != 0) begin
        failures++;
        $display("FAIL tx_bit%0d: %0d clocks differ from required level %b", i, bad[i], fb[i]);
      end
    end
    checks++;
    if (busy_err != 0) begin
      failures++;
      $display("FAIL tx_busy_window: %0d clocks with tx_busy!=1 or tx_done!=0, required 0", busy_err);
    end
    busy_err = 0;
    repeat (3 * BD) begin
      @(negedge clk);
      if (tx_line !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) busy_err++;
    end
    checks++;
    if (busy_err != 0) begin
      failures++;
      $display("FAIL tx_ignored_request: %0d clocks not idle after frame, required 0", busy_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words[4];
    logic [19:0] bits;
    logic        found;
    logic        seen;
    for (int k = 0; k < 4; k++) words[k] = 16'($urandom);
    pulse_send(words[0]);
    for (int k = 0; k < 4; k++) begin
      capture_frame(bits, found);
      checks++;
      if (!found || bits !== frame_bits(words[k])) begin
        failures++;
        $display("FAIL b2b_frame%0d: found=%b bits=%h, required bits=%h", k, found, bits, frame_bits(words[k]));
      end
      wait_done(seen);
      if (k < 3) begin
        checks++;
        if (!seen || tx_line !== 1'b1) begin
          failures++;
          $display("FAIL b2b_done%0d: tx_done seen=%b TX_C=%b, required 1 1", k, seen, tx_line);
        end
        rsp      = words[k + 1];
        send_rsp = 1'b1;
        @(negedge clk);
        send_rsp = 1'b0;
        checks++;
        if (tx_line !== 1'b0 || tx_busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_restart%0d: TX_C=%b tx_busy=%b one cycle after tx_done, required 0 1",
                   k, tx_line, tx_busy);
        end
      end else begin
        checks++;
        if (!seen) begin
          failures++;
          $display("FAIL b2b_last_done: tx_done seen=0, required 1");
        end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rx_errors();
    send_byte(8'h5A, 1'b1);
    idle_bits(1);
    send_byte(8'h00, 1'b0);
    idle_bits(1);
    checks++;
    if (cmd !== exp_cmd || cmd_rdy !== exp_rdy) begin
      failures++;
      $display("FAIL framing_discard: cmd=%h cmd_rdy=%b, required %h %b", cmd, cmd_rdy, exp_cmd, exp_rdy);
    end
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    checks++;
    if (cmd !== 24'h010203 || cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL framing_recover: cmd=%h cmd_rdy=%b, required 010203 1", cmd, cmd_rdy);
    end
    idle_bits(1);
    glitch();
    checks++;
    if (cmd !== exp_cmd || cmd_rdy !== exp_rdy) begin
      failures++;
      $display("FAIL glitch_new_cmd: cmd=%h cmd_rdy=%b, required %h %b", cmd, cmd_rdy, exp_cmd, exp_rdy);
    end
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    glitch();
    send_byte(8'h99, 1'b1);
    checks++;
    if (cmd !== 24'h778899 || cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_no_byte: cmd=%h cmd_rdy=%b, required 778899 1", cmd, cmd_rdy);
    end
    idle_bits(1);
  endtask

  task automatic test_timeout();
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    idle_bits(33);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    checks++;
    if (cmd !== 24'h112233 || cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_discard: cmd=%h cmd_rdy=%b, required 112233 1", cmd, cmd_rdy);
    end
    idle_bits(1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    idle_bits(10);
    send_byte(8'h11, 1'b1);
    checks++;
    if (cmd !== 24'hABCD11 || cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_short_gap: cmd=%h cmd_rdy=%b, required abcd11 1", cmd, cmd_rdy);
    end
    idle_bits(1);
  endtask

  task automatic test_rx_random();
    logic [7:0] b;
    logic       ok;
    for (int i = 0; i < 12; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_byte(b, ok);
      checks++;
      if (cmd !== exp_cmd || cmd_rdy !== exp_rdy) begin
        failures++;
        $display("FAIL rx_random%0d: cmd=%h cmd_rdy=%b, required %h %b", i, cmd, cmd_rdy, exp_cmd, exp_rdy);
      end
      if ($urandom_range(0, 3) == 0) idle_bits(int'($urandom_range(36, 40)));
      else idle_bits(int'($urandom_range(0, 6)));
    end
    idle_bits(40);
  endtask

  task automatic test_concurrent();
    logic [15:0] w;
    logic [19:0] bits;
    logic        found;
    logic        seen;
    logic [7:0]  b0, b1, b2;
    w  = 16'($urandom);
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    fork
      begin
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
      end
      begin
        repeat (BD * 3) @(negedge clk);
        pulse_send(w);
        capture_frame(bits, found);
        wait_done(seen);
      end
    join
    checks++;
    if (cmd !== {b0, b1, b2} || cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL concurrent_rx: cmd=%h cmd_rdy=%b, required %h 1", cmd, cmd_rdy, {b0, b1, b2});
    end
    checks++;
    if (!found || !seen || bits !== frame_bits(w)) begin
      failures++;
      $display("FAIL concurrent_tx: found=%b done=%b bits=%h, required 1 1 %h", found, seen, bits, frame_bits(w));
    end
    idle_bits(1);
  endtask

  task automatic test_clr_collision();
    logic seen;
    int   w;
    send_byte(8'hC1, 1'b1);
    send_byte(8'hC2, 1'b1);
    checks++;
    if (cmd_rdy !== 1'b0) begin
      failures++;
      $display("FAIL collision_pre: cmd_rdy=%b before third byte, required 0", cmd_rdy);
    end
    fork
      send_byte(8'hC3, 1'b1);
      begin
        clr_cmd_rdy = 1'b1;
        w = 0;
        while (cmd_rdy !== 1'b1 && w < 12 * BD) begin
          @(negedge clk);
          w++;
        end
        clr_cmd_rdy = 1'b0;
        seen = (cmd_rdy === 1'b1);
      end
    join
    repeat (3) @(negedge clk);
    checks++;
    if (!seen || cmd_rdy !== 1'b1 || cmd !== 24'hC1C2C3) begin
      failures++;
      $display("FAIL collision_set_wins: seen=%b cmd_rdy=%b cmd=%h, required 1 1 c1c2c3", seen, cmd_rdy, cmd);
    end
    idle_bits(1);
  endtask

  task automatic test_reset_mid();
    pulse_send(16'($urandom));
    send_byte(8'h4E, 1'b1);
    @(negedge clk);
    rx_line = 1'b0;
    repeat (3 * BD) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_line !== 1'b1 || cmd !== 24'h0 || cmd_rdy !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_frame: TX_C=%b cmd=%h cmd_rdy=%b tx_busy=%b tx_done=%b, required 1 000000 0 0 0",
               tx_line, cmd, cmd_rdy, tx_busy, tx_done);
    end
    rx_line = 1'b1;
    pend.delete();
    exp_cmd  = '0;
    exp_rdy  = 1'b0;
    gap_bits = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_bits(4);
    send_byte(8'hD4, 1'b1);
    send_byte(8'hE5, 1'b1);
    send_byte(8'hF6, 1'b1);
    checks++;
    if (cmd !== 24'hD4E5F6 || cmd_rdy !== 1'b1 || tx_line !== 1'b1) begin
      failures++;
      $display("FAIL reset_recover: cmd=%h cmd_rdy=%b TX_C=%b, required d4e5f6 1 1", cmd, cmd_rdy, tx_line);
    end
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_tx_basic();
    test_back_to_back();
    test_rx_errors();
    test_timeout();
    test_rx_random();
    test_concurrent();
    test_clr_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfg_uart.md
# cfg_uart

Configuration-port UART endpoint inside `cbc_dig`, at the opposite end of the serial link from the bench's `cfg_mstr`. It receives 24-bit command frames on `RX_C` as three 8N1 bytes and presents them to the command processor as `cmd`/`cmd_rdy`. It also serializes 16-bit responses back to the master on `TX_C` as two 8N1 bytes. Receive and transmit paths are independent and may run concurrently.

## Interface
- `BAUD_DIV`, 4340, clocks per bit period; 500 MHz / 115200 baud. Must be >= 8.
- `TO_BITS`, 32, inter-byte timeout in bit periods; a partially received command is discarded after this long.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `RX_C`  in  1  serial command input from master, idle high, asynchronous to `clk`.
- `TX_C`  out  1  serial response output to master, idle high.
- `cmd`  out  24  last complete command; first received byte in [23:16], last in [7:0].
- `cmd_rdy`  out  1  level; high while `cmd` holds an unconsumed command.
- `clr_cmd_rdy`  in  1  one-cycle consume strobe from the command processor.
- `rsp`  in  16  response word; sampled when `send_rsp` is accepted.
- `send_rsp`  in  1  one-cycle request to transmit `rsp`.
- `tx_busy`  out  1  high from acceptance of `send_rsp` until the second stop bit completes.
- `tx_done`  out  1  one-cycle pulse when the response has been fully sent.

## Operation
- Reset values: `TX_C`=1, `cmd`=0, `cmd_rdy`=0, `tx_busy`=0, `tx_done`=0. The RX synchronizer flops reset to 1. All counters reset to 0 and both FSMs reset to IDLE.
- RX front end: `RX_C` passes through a 2-flop synchronizer. All RX decisions use the synchronized signal `rx_s`.
- RX FSM states are IDLE, START, DATA, STOP.
  - IDLE → START when `rx_s` is 0 while `rx_s` was 1 on the previous cycle (falling edge).
  - START: after BAUD_DIV/2 clocks (integer division), sample `rx_s`. If 1, it is a false start: go to IDLE and leave the byte count unchanged. If 0, go to DATA.
  - DATA: sample 8 bits, one every BAUD_DIV clocks, LSB first, into a shift register.
  - STOP: sample once, BAUD_DIV clocks after the last data bit.
    - If the stop bit is 1, the byte is good. Increment the byte count (0→1→2). On the third good byte, load `cmd` as {byte0, byte1, byte2}, set `cmd_rdy`, and reset the byte count to 0.
    - If the stop bit is 0, it is a framing error. Discard the byte and reset the byte count to 0.
    - In both cases, return to IDLE.
- `cmd_rdy` clears on `clr_cmd_rdy`. It also clears when START is entered with byte count 0, which means a new command is beginning.
  - If a set and a clear occur in the same cycle, the set wins.
  - `cmd` holds its value until the next complete command is loaded.
- Timeout: while the byte count is nonzero and the RX FSM is IDLE, a counter runs. When it reaches TO_BITS*BAUD_DIV clocks, the byte count resets to 0. The counter clears on every START entry.
- TX FSM states are IDLE, START, DATA, STOP, with a byte select bit.
  - In IDLE, `send_rsp` latches `rsp` and sets `tx_busy`.
  - Byte 0 is `rsp[15:8]`; byte 1 is `rsp[7:0]`.
  - Each byte is sent as start bit 0, then 8 data bits LSB first, then stop bit 1. Byte 1's start bit follows byte 0's stop bit directly, with no idle gap.
  - `send_rsp` while `tx_busy` is high is ignored. The latched word is not altered.
- A reset asserted mid-frame aborts either path immediately and restores reset values. A partial command is lost and `TX_C` returns high.

## Timing
- Every TX bit is exactly BAUD_DIV clocks long. A response frame is therefore 20*BAUD_DIV clocks.
- `TX_C` goes to 0 on the first clock edge after the cycle in which `send_rsp` is accepted. `tx_busy` rises on that same edge.
- `tx_done` pulses for one cycle on the edge where byte 1's stop bit completes. `tx_busy` falls on that same edge.
- A `send_rsp` in the `tx_done` cycle is accepted. The next frame's start bit then begins one cycle later.
- RX sample points:
  - The start bit is checked BAUD_DIV/2 clocks after the falling edge is seen on `rx_s`.
  - Data bit k (k=0..7) is sampled BAUD_DIV*(k+1) clocks after the start check.
  - The stop bit is sampled BAUD_DIV*9 clocks after the start check.
- `cmd` and `cmd_rdy` update on the clock edge after the third stop-bit sample.
- The receiver tolerates at least ±3% baud mismatch.

## Test plan
- Basic receive: BAUD_DIV=16; master sends 0xA5_3C_0F → after byte 2's stop-bit sample, `cmd`=0xA53C0F and `cmd_rdy`=1. A `clr_cmd_rdy` pulse → `cmd_rdy`=0 and `cmd` unchanged.
- Basic transmit: `rsp`=0x12F0 with `send_rsp` pulsed → `TX_C` carries 0x12 then 0xF0, LSB first, each bit 16 clocks. `tx_done` pulses at clock 320 after acceptance. A `send_rsp` with 0xFFFF at clock 100 is ignored.
- Error handling: a 0x00 byte sent with stop bit 0 after one good byte → framing error, byte count returns to 0. A following clean 3-byte 0x010203 → `cmd`=0x010203.
  - A 6-clock low glitch on `RX_C` → false start, no byte received.
- Timeout: send 0xAB, 0xCD, then idle for 33 bit periods, then send 0x11, 0x22, 0x33 → `cmd`=0x112233.
  - The same sequence with only a 10-bit-period gap → `cmd`=0xABCD11.
- Concurrency and reset: loop `TX_C` into `cfg_mstr` while a command is being received, and check both frames arrive intact.
  - `clr_cmd_rdy` in the same cycle as a new command completes → `cmd_rdy` stays 1.
  - `rst_n` low in the middle of byte 1 → all outputs return to reset values; a subsequent clean command is received correctly.
